// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one memory port between instruction-side
// and data-side requesters (block fills and single-word writes).
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_req,
  input  logic [15:0]                    i_addr,
  input  logic                           d_req,
  input  logic                           d_wr,
  input  logic [15:0]                    d_addr,
  input  logic [15:0]                    d_wdata,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [15:0]                    mem_addr,
  output logic [15:0]                    mem_wdata,
  input  logic [15:0]                    mem_rdata,
  input  logic                           mem_valid,
  output logic [15:0]                    i_fill_data,
  output logic [15:0]                    d_fill_data,
  output logic                           i_fill_valid,
  output logic                           d_fill_valid,
  output logic [$clog2(BLOCK_WORDS)-1:0] i_fill_idx,
  output logic [$clog2(BLOCK_WORDS)-1:0] d_fill_idx,
  output logic                           i_done,
  output logic                           d_done,
  output logic                           busy
);

  localparam int IW   = $clog2(BLOCK_WORDS);
  localparam int CW   = IW + 1;
  localparam int OFFW = $clog2(2 * BLOCK_WORDS);

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("MEM_LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_I_FILL,
    ST_D_FILL,
    ST_D_WRITE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last_d;
  logic [CW-1:0]   r_issue_cnt;
  logic [IW-1:0]   r_ret_cnt;
  logic [15:0]     r_addr;
  logic [15:0]     r_wdata;

  logic            w_idle;
  logic            w_fill;
  logic            w_grant_d;
  logic            w_grant_i;
  logic            w_issue;
  logic            w_ret;
  logic            w_last;
  logic [15:0]     w_i_base;
  logic [15:0]     w_d_base;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_fill   = (r_state == ST_I_FILL) |
                    (r_state == ST_D_FILL);

  // On a tie, serve the side that was not served last
  assign w_grant_d = w_idle & d_req &
                     (~i_req | ~r_last_d);
  assign w_grant_i = w_idle & i_req & ~w_grant_d;

  assign w_i_base = {i_addr[15:OFFW], OFFW'(0)};
  assign w_d_base = {d_addr[15:OFFW], OFFW'(0)};

  assign w_issue = w_fill &
                   (r_issue_cnt < CW'(BLOCK_WORDS));
  assign w_ret   = w_fill & mem_valid;
  assign w_last  = w_ret &
                   (r_ret_cnt == IW'(BLOCK_WORDS - 1));

  // Read returns go only to the side owning the fill
  assign i_fill_valid = (r_state == ST_I_FILL) & mem_valid;
  assign d_fill_valid = (r_state == ST_D_FILL) & mem_valid;
  assign i_fill_idx   = (r_state == ST_I_FILL) ?
                        r_ret_cnt : '0;
  assign d_fill_idx   = (r_state == ST_D_FILL) ?
                        r_ret_cnt : '0;
  assign i_fill_data  = rst_n ? mem_rdata : '0;
  assign d_fill_data  = rst_n ? mem_rdata : '0;
  assign busy         = ~w_idle;

  // Next state, memory strobes and completion pulses
  always_comb begin
    w_next    = r_state;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_next = d_wr ? ST_D_WRITE : ST_D_FILL;
        end else if (w_grant_i) begin
          w_next = ST_I_FILL;
        end
      end
      ST_I_FILL, ST_D_FILL: begin
        mem_en = w_issue;
        if (w_issue) begin
          mem_addr = r_addr +
                     16'({r_issue_cnt, 1'b0});
        end
        if (w_last) begin
          w_next = ST_IDLE;
          i_done = (r_state == ST_I_FILL);
          d_done = (r_state == ST_D_FILL);
        end
      end
      ST_D_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        d_done    = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, grant capture and issue/return counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_last_d    <= 1'b0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_d | w_grant_i) begin
        r_last_d    <= w_grant_d;
        r_issue_cnt <= '0;
        r_ret_cnt   <= '0;
        r_wdata     <= d_wdata;
        if (w_grant_d) begin
          r_addr <= d_wr ? d_addr : w_d_base;
        end else begin
          r_addr <= w_i_base;
        end
      end else begin
        if (w_issue) begin
          r_issue_cnt <= r_issue_cnt + CW'(1);
        end
        if (w_ret) begin
          r_ret_cnt <= r_ret_cnt + IW'(1);
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 8: 16-bit words per cache-block fill.
REQ-002 SHALL have parameter MEM_LATENCY, default 4: cycles from a memory read issue to its mem_valid.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port i_req, input, 1: instruction-side block fill request, held until i_done.
REQ-006 SHALL have port i_addr, input, 16: instruction miss byte address.
REQ-007 SHALL have port d_req, input, 1: data-side request, held until d_done.
REQ-008 SHALL have port d_wr, input, 1: qualifies d_req; 1 = single-word write, 0 = block fill.
REQ-009 SHALL have port d_addr, input, 16: data byte address.
REQ-010 SHALL have port d_wdata, input, 16: write data.
REQ-011 SHALL have port mem_en, output, 1: memory access strobe, one access per cycle.
REQ-012 SHALL have port mem_wr, output, 1: 1 = write, 0 = read.
REQ-013 SHALL have port mem_addr, output, 16: memory byte address.
REQ-014 SHALL have port mem_wdata, output, 16: memory write data.
REQ-015 SHALL have port mem_rdata, input, 16: memory read data.
REQ-016 SHALL have port mem_valid, input, 1: mem_rdata is valid this cycle.
REQ-017 SHALL have ports i_fill_data / d_fill_data, output, 16: returned word, equal to mem_rdata.
REQ-018 SHALL have ports i_fill_valid / d_fill_valid, output, 1: fill word valid.
REQ-019 SHALL have ports i_fill_idx / d_fill_idx, output, log2(BLOCK_WORDS): word index within the block.
REQ-020 SHALL have ports i_done / d_done, output, 1: one-cycle transaction-complete pulse.
REQ-021 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-022 SHALL implement FSM states IDLE, I_FILL, D_FILL, D_WRITE.
REQ-023 SHALL arbitrate only in IDLE; the grant takes effect at the next edge; the first mem_en occurs in the first cycle of the service state.
REQ-024 SHALL resolve simultaneous i_req and d_req round-robin: the grant goes to the side not served last; the last-served register resets to I, so the first tie goes to D.
REQ-025 SHALL go IDLE->D_WRITE on d_req&d_wr, IDLE->D_FILL on d_req&~d_wr, and IDLE->I_FILL on i_req.
REQ-026 SHALL align the block base as addr with its low log2(2*BLOCK_WORDS) bits cleared (0x0010-byte blocks at default).
REQ-027 SHALL in a fill state issue BLOCK_WORDS consecutive reads, one per cycle, at mem_addr = base + 2*issue_cnt with mem_wr=0; issue_cnt counts 0..BLOCK_WORDS and stops.
REQ-028 SHALL route mem_valid in a fill state to the owner's fill_valid, with fill_idx = ret_cnt, incrementing ret_cnt by one per mem_valid.
REQ-029 SHALL pulse the owner's done in the same cycle as the fill_valid for word BLOCK_WORDS-1, and return to IDLE at the next edge.
REQ-030 SHALL in D_WRITE drive mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata for exactly one cycle, pulse d_done in that cycle, then return to IDLE.
REQ-031 SHALL ignore requester deassertion mid-transaction; the transaction completes.
REQ-032 SHALL ignore mem_valid in IDLE and D_WRITE, and for the non-owning side.
REQ-033 SHALL hold mem_en=0 and mem_wr=0, with mem_addr/mem_wdata don't-care, whenever no access is issued.
REQ-034 SHALL accept a request held across done as a new request in IDLE, giving at least one idle cycle between transactions.
REQ-035 SHALL capture base address and direction at grant, so later i_addr/d_addr changes have no effect.

Reset
REQ-036 SHALL on rst_n=0, immediately and asynchronously, set state=IDLE, counters=0, last-served=I, and all outputs to 0.
REQ-037 SHALL abandon an in-flight transaction on reset mid-operation: no done pulse, and post-reset mem_valid ignored until the next grant.

Verification
REQ-038 SHALL cover I fill: i_req, i_addr=0x1236 -> reads 0x1230..0x123E on 8 consecutive cycles; i_fill_idx 0..7; i_done with word 7, MEM_LATENCY cycles after the last issue.
REQ-039 SHALL cover a tie: i_req and d_req (fill, d_addr=0x0040) both asserted from reset -> D_FILL served first (0x0040..0x004E), then I_FILL; the next tie goes to D.
REQ-040 SHALL cover a write: d_req, d_wr, d_addr=0x2000, d_wdata=0xBEEF -> one cycle mem_en=1, mem_wr=1, addr 0x2000, data 0xBEEF, with d_done in that cycle.
REQ-041 SHALL cover a late request: i_req raised during D_FILL -> no I access until D_FILL's d_done plus one idle cycle.
REQ-042 SHALL cover reset mid-fill: rst_n low after 3 returned words -> outputs 0 at once, no done pulse, stray mem_valid ignored, and a new fill starts at idx 0.
